pupil_search_ctrl: RTL
======================

PUPIL_SEARCH_CTRL -- requirements
Module: pupil_search_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640: search image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 480: search image height in pixels.
REQ-003 SHALL have parameter TPL_W, default 64: template width; TPL_W <= IMG_W.
REQ-004 SHALL have parameter TPL_H, default 64: template height; TPL_H <= IMG_H.
REQ-005 SHALL have parameter STEP, default 8: candidate grid pitch in X and Y, >= 1.
REQ-006 SHALL have parameter SCORE_W, default 32: score width.
REQ-007 SHALL have parameter TIMEOUT, default 2^20: maximum WAIT cycles per candidate.
REQ-008 SHALL have port iCLK, input, 1: single clock, rising edge.
REQ-009 SHALL have port iRST_N, input, 1: asynchronous active-low reset.
REQ-010 SHALL have port iStart, input, 1: start full search; sampled in IDLE only.
REQ-011 SHALL have port iAbort, input, 1: cancel search.
REQ-012 SHALL have port oCorr_start, output, 1: one-cycle start pulse to the scorer.
REQ-013 SHALL have port oXstart, output, 13: candidate X origin.
REQ-014 SHALL have port oYstart, output, 13: candidate Y origin.
REQ-015 SHALL have port iCorr_done, input, 1: one-cycle scorer completion pulse.
REQ-016 SHALL have port iCorr_score, input, SCORE_W: scorer result, valid with iCorr_done.
REQ-017 SHALL have port oBusy, output, 1: search in progress.
REQ-018 SHALL have port oDone, output, 1: one-cycle pulse on search completion.
REQ-019 SHALL have port oError, output, 1: scorer timeout flag.
REQ-020 SHALL have ports oBest_X (13), oBest_Y (13), oBest_score (SCORE_W), all outputs: best match.

Function
REQ-021 SHALL implement states IDLE, ISSUE, WAIT, UPDATE, NEXT, FINISH.
REQ-022 SHALL, on iStart=1 in IDLE, clear oXstart/oYstart to 0, clear oError, set first-flag, enter ISSUE next cycle.
REQ-023 SHALL ignore iStart outside IDLE.
REQ-024 SHALL assert oCorr_start for exactly the ISSUE cycle, then enter WAIT.
REQ-025 SHALL hold oXstart/oYstart stable from ISSUE through UPDATE.
REQ-026 SHALL, in WAIT, on iCorr_done=1 capture iCorr_score and enter UPDATE; iCorr_done outside WAIT ignored.
REQ-027 SHALL, in UPDATE, load best regs from candidate if first-flag set or score > oBest_score (unsigned, strict); ties keep earlier raster candidate; clear first-flag.
REQ-028 SHALL, in NEXT: if oXstart+STEP <= IMG_W-TPL_W, advance X; else X=0 and, if oYstart+STEP <= IMG_H-TPL_H, advance Y; else FINISH. Non-FINISH goes to ISSUE.
REQ-029 SHALL visit (floor((IMG_W-TPL_W)/STEP)+1) x (floor((IMG_H-TPL_H)/STEP)+1) candidates in raster order, X fastest.
REQ-030 SHALL compute coordinate sums at >= 14 bits so no wrap occurs.
REQ-031 SHALL pulse oDone for the single FINISH cycle, then return to IDLE.
REQ-032 SHALL drive oBusy=1 in every state except IDLE.
REQ-033 SHALL count WAIT cycles; on reaching TIMEOUT without iCorr_done, set oError=1, go IDLE, no oDone.
REQ-034 SHALL, on iAbort=1 in any non-IDLE state, go IDLE next cycle, no oDone, best regs retain partial values; iAbort has priority over iCorr_done in the same cycle.
REQ-035 SHALL update best regs only in UPDATE; they remain stable in IDLE.

Reset
REQ-036 SHALL, on iRST_N=0, immediately enter IDLE and clear all outputs and internal counters/flags to 0, including mid-search.
REQ-037 SHALL resume normal operation on the first iCLK edge after iRST_N deasserts.

Verification (bench params IMG_W=16, IMG_H=12, TPL_W=8, TPL_H=8, STEP=4, TIMEOUT=16)
REQ-038 SHALL cover full search: scorer returns 10,20,50,30,50,5 -> origins (0,0),(4,0),(8,0),(0,4),(4,4),(8,4), one oCorr_start each, oDone once, best=(8,0,50).
REQ-039 SHALL cover first-candidate load: all scores 0 -> best=(0,0,0), oDone pulses.
REQ-040 SHALL cover timeout: no iCorr_done for 16 WAIT cycles -> oError=1, oBusy=0, no oDone; next iStart clears oError.
REQ-041 SHALL cover abort: iAbort during 3rd WAIT, same cycle as iCorr_done -> IDLE, no oDone, best reflects first 2 candidates.
REQ-042 SHALL cover reset mid-WAIT: iRST_N low -> all outputs 0 asynchronously; iStart after release restarts at (0,0).
REQ-043 SHALL cover ignored inputs: iStart while busy and stray iCorr_done in ISSUE/IDLE -> no effect on sequence or best.

Source files
------------

// File: rtl/pupil_search_ctrl.sv
// Raster-scan search controller: issues template-match candidates to an external scorer
// and tracks the best-scoring origin, with per-candidate timeout and abort.
module pupil_search_ctrl #(
   parameter int unsigned IMG_W   = 640,
   parameter int unsigned IMG_H   = 480,
   parameter int unsigned TPL_W   = 64,
   parameter int unsigned TPL_H   = 64,
   parameter int unsigned STEP    = 8,
   parameter int unsigned SCORE_W = 32,
   parameter int unsigned TIMEOUT = 1048576
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic               iStart,
   input  logic               iAbort,
   output logic               oCorr_start,
   output logic [12:0]        oXstart,
   output logic [12:0]        oYstart,
   input  logic               iCorr_done,
   input  logic [SCORE_W-1:0] iCorr_score,
   output logic               oBusy,
   output logic               oDone,
   output logic               oError,
   output logic [12:0]        oBest_X,
   output logic [12:0]        oBest_Y,
   output logic [SCORE_W-1:0] oBest_score
);

   localparam int unsigned X_LAST = IMG_W - TPL_W;
   localparam int unsigned Y_LAST = IMG_H - TPL_H;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StUpdate,
      StNext,
      StFinish
   } state_e;

   state_e               state_q, state_d;
   logic [12:0]          x_q, x_d;
   logic [12:0]          y_q, y_d;
   logic                 first_q, first_d;
   logic                 err_q, err_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [12:0]          best_x_q, best_x_d;
   logic [12:0]          best_y_q, best_y_d;
   logic [SCORE_W-1:0]   best_score_q, best_score_d;
   logic [13:0]          x_sum, y_sum;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q      <= StIdle;
         x_q          <= '0;
         y_q          <= '0;
         first_q      <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         score_q      <= '0;
         best_x_q     <= '0;
         best_y_q     <= '0;
         best_score_q <= '0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         first_q      <= first_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
         score_q      <= score_d;
         best_x_q     <= best_x_d;
         best_y_q     <= best_y_d;
         best_score_q <= best_score_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      first_d      = first_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      score_d      = score_q;
      best_x_d     = best_x_q;
      best_y_d     = best_y_q;
      best_score_d = best_score_q;
      // One extra bit so origin + STEP never wraps before the range compare.
      x_sum        = {1'b0, x_q} + 14'(STEP);
      y_sum        = {1'b0, y_q} + 14'(STEP);

      if (state_q != StIdle && iAbort) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (iStart) begin
                  x_d     = '0;
                  y_d     = '0;
                  err_d   = 1'b0;
                  first_d = 1'b1;
                  state_d = StIssue;
               end
            end
            StIssue: begin
               cnt_d   = '0;
               state_d = StWait;
            end
            StWait: begin
               if (iCorr_done) begin
                  score_d = iCorr_score;
                  state_d = StUpdate;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StUpdate: begin
               // Strict compare keeps the earliest raster candidate on ties.
               if (first_q || (score_q > best_score_q)) begin
                  best_x_d     = x_q;
                  best_y_d     = y_q;
                  best_score_d = score_q;
               end
               first_d = 1'b0;
               state_d = StNext;
            end
            StNext: begin
               if (x_sum <= 14'(X_LAST)) begin
                  x_d     = x_sum[12:0];
                  state_d = StIssue;
               end else begin
                  x_d = '0;
                  if (y_sum <= 14'(Y_LAST)) begin
                     y_d     = y_sum[12:0];
                     state_d = StIssue;
                  end else begin
                     state_d = StFinish;
                  end
               end
            end
            StFinish: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   assign oCorr_start = (state_q == StIssue);
   assign oDone       = (state_q == StFinish);
   assign oBusy       = (state_q != StIdle);
   assign oError      = err_q;
   assign oXstart     = x_q;
   assign oYstart     = y_q;
   assign oBest_X     = best_x_q;
   assign oBest_Y     = best_y_q;
   assign oBest_score = best_score_q;

endmodule
